// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   INST_ADDR_BUS_W / INST_BUS_W : instruction address and instruction word widths
//   DEFAULT_INDEX_W              : default number of index bits (2^7 one-word lines)
//   icache_state_e               : controller states ICACHE_IDLE / ICACHE_MISS / ICACHE_DRAIN
package icache_direct_pkg;

    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W      = 32;
    localparam int DEFAULT_INDEX_W = 7;

    typedef enum logic [1:0] {
        ICACHE_IDLE  = 2'd0,
        ICACHE_MISS  = 2'd1,
        ICACHE_DRAIN = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and fill-side signals of the instruction cache.
//   IF side : if_req_i/if_pc_i in, if_ready_o/if_valid_o/if_inst_o/if_inst_pc_o out
//   MC side : mc_req_o/mc_addr_o out, mc_ack_i/mc_data_i in
// Handshake rules: a fetch is accepted in a cycle where if_req_i && if_ready_o;
// if_valid_o is a one-cycle pulse carrying the word and its PC. mc_req_o is a
// level held until the one-cycle mc_ack_i pulse, which carries mc_data_i.
// Modport slave is the cache; modport master is the IF stage plus memory controller.
interface icache_direct_if
    import icache_direct_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS_W
) ();
    logic                  if_req_i;
    logic [ADDR_W-1:0]     if_pc_i;
    logic                  if_ready_o;
    logic                  if_valid_o;
    logic [INST_BUS_W-1:0] if_inst_o;
    logic [ADDR_W-1:0]     if_inst_pc_o;
    logic                  mc_req_o;
    logic [ADDR_W-1:0]     mc_addr_o;
    logic                  mc_ack_i;
    logic [INST_BUS_W-1:0] mc_data_i;

    modport slave (
        input  if_req_i, if_pc_i, mc_ack_i, mc_data_i,
        output if_ready_o, if_valid_o, if_inst_o, if_inst_pc_o, mc_req_o, mc_addr_o
    );

    modport master (
        output if_req_i, if_pc_i, mc_ack_i, mc_data_i,
        input  if_ready_o, if_valid_o, if_inst_o, if_inst_pc_o, mc_req_o, mc_addr_o
    );
endinterface

// File: rtl/icache_array.sv
// Tag/data storage plus per-line valid vector for the direct-mapped cache.
//   clk, rst_n      : clock, synchronous active-low reset (clears valid bits only)
//   en              : global ready; nothing updates while low
//   wr_en/wr_index/wr_tag/wr_data : single write port, sets the line valid
//   clear_all       : clears every valid bit; takes precedence over a write's valid set
//   rd_index -> rd_valid/rd_tag/rd_data : asynchronous read
module icache_array
    import icache_direct_pkg::*;
#(
    parameter int INDEX_W = DEFAULT_INDEX_W,
    parameter int TAG_W   = INST_ADDR_BUS_W - DEFAULT_INDEX_W - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [INST_BUS_W-1:0] wr_data,
    input  logic                  clear_all,
    input  logic [INDEX_W-1:0]    rd_index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [INST_BUS_W-1:0] rd_data
);
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [INST_BUS_W-1:0] data_mem [LINES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (en) begin
            if (clear_all) begin
                valid_q <= '0;
            end else if (wr_en) begin
                valid_q[wr_index] <= 1'b1;
            end
        end
    end

    // Tag/data are written even when clear_all wins, so the RAM has no reset.
    always_ff @(posedge clk) begin
        if (en && wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache between IF and the memory
// controller instruction port. Hits return one cycle later; misses fetch a
// single word, fill the line and return it. Supports branch flush and fence.i.
//   clk_in, rst_in (sync, active-low), rdy_in (global freeze)
//   flush_i : cancel the outstanding fetch
//   inv_i   : invalidate all lines
//   state_o : current controller state (debug)
//   bus     : IF and MC signals (icache_direct_if.slave)
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_W = DEFAULT_INDEX_W,
    parameter int ADDR_W  = INST_ADDR_BUS_W
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush_i,
    input  logic          inv_i,
    output icache_state_e state_o,
    icache_direct_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    icache_state_e         state_q;
    logic [ADDR_W-1:0]     pc_q;
    logic                  inv_pend_q;
    logic                  if_valid_q;
    logic [INST_BUS_W-1:0] if_inst_q;
    logic [ADDR_W-1:0]     if_inst_pc_q;
    logic                  mc_req_q;
    logic [ADDR_W-1:0]     mc_addr_q;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [INST_BUS_W-1:0] rd_data;
    logic                  hit;
    logic                  fill;
    logic                  clear_all;

    // An invalidate in the same cycle as a lookup forces a miss.
    assign hit  = rd_valid && (rd_tag == bus.if_pc_i[ADDR_W-1:INDEX_W+2]) && !inv_i;
    assign fill = (state_q != ICACHE_IDLE) && bus.mc_ack_i;
    // During a fill, the clear lands after the write, leaving the new line invalid too.
    assign clear_all = ((state_q == ICACHE_IDLE) && inv_i) || (fill && (inv_pend_q || inv_i));

    icache_array #(
        .INDEX_W(INDEX_W),
        .TAG_W  (TAG_W)
    ) u_array (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .en       (rdy_in),
        .wr_en    (fill),
        .wr_index (pc_q[INDEX_W+1:2]),
        .wr_tag   (pc_q[ADDR_W-1:INDEX_W+2]),
        .wr_data  (bus.mc_data_i),
        .clear_all(clear_all),
        .rd_index (bus.if_pc_i[INDEX_W+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= ICACHE_IDLE;
            pc_q         <= '0;
            inv_pend_q   <= 1'b0;
            if_valid_q   <= 1'b0;
            if_inst_q    <= '0;
            if_inst_pc_q <= '0;
            mc_req_q     <= 1'b0;
            mc_addr_q    <= '0;
        end else if (rdy_in) begin
            if_valid_q <= 1'b0;
            case (state_q)
                ICACHE_IDLE: begin
                    if (bus.if_req_i && !flush_i) begin
                        if (hit) begin
                            if_valid_q   <= 1'b1;
                            if_inst_q    <= rd_data;
                            if_inst_pc_q <= bus.if_pc_i;
                        end else begin
                            pc_q      <= bus.if_pc_i;
                            mc_req_q  <= 1'b1;
                            mc_addr_q <= {bus.if_pc_i[ADDR_W-1:2], 2'b00};
                            state_q   <= ICACHE_MISS;
                        end
                    end
                end
                ICACHE_MISS: begin
                    if (bus.mc_ack_i) begin
                        mc_req_q   <= 1'b0;
                        inv_pend_q <= 1'b0;
                        state_q    <= ICACHE_IDLE;
                        if (!flush_i) begin
                            if_valid_q   <= 1'b1;
                            if_inst_q    <= bus.mc_data_i;
                            if_inst_pc_q <= pc_q;
                        end
                    end else begin
                        if (inv_i) inv_pend_q <= 1'b1;
                        // The fill is already issued; drain it instead of aborting.
                        if (flush_i) state_q <= ICACHE_DRAIN;
                    end
                end
                ICACHE_DRAIN: begin
                    if (bus.mc_ack_i) begin
                        mc_req_q   <= 1'b0;
                        inv_pend_q <= 1'b0;
                        state_q    <= ICACHE_IDLE;
                    end else if (inv_i) begin
                        inv_pend_q <= 1'b1;
                    end
                end
                default: state_q <= ICACHE_IDLE;
            endcase
        end
    end

    assign state_o          = state_q;
    assign bus.if_ready_o   = (state_q == ICACHE_IDLE);
    assign bus.if_valid_o   = if_valid_q;
    assign bus.if_inst_o    = if_inst_q;
    assign bus.if_inst_pc_o = if_inst_pc_q;
    assign bus.mc_req_o     = mc_req_q;
    assign bus.mc_addr_o    = mc_addr_q;
endmodule
